// File: rtl/sync_counter_monitor_if.sv
// Observation bus between an up/down counter under test and its monitor.
// The master side drives the counter's count/up and the error clear;
// the slave side is the monitor, which returns lock status and events.
interface sync_counter_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
);
  logic             up;
  logic [WIDTH-1:0] count;
  logic             clr_err;
  logic             locked;
  logic             mismatch;
  logic             err_sticky;
  logic [ERRW-1:0]  err_count;
  logic             wrap_up;
  logic             wrap_down;
  logic             dir_change;
  logic [WIDTH-1:0] expected;

  modport master (
    output up, count, clr_err,
    input  locked, mismatch, err_sticky, err_count,
    input  wrap_up, wrap_down, dir_change, expected
  );

  modport slave (
    input  up, count, clr_err,
    output locked, mismatch, err_sticky, err_count,
    output wrap_up, wrap_down, dir_change, expected
  );
endinterface

// File: rtl/sync_counter_monitor.sv
// Receive-side checker for a synchronous up/down counter. Predicts each
// sample from the previous one, acquires lock after LOCK_MATCHES correct
// predictions, then flags mismatches, wraps and direction changes.
// Every output is a register; results for the sample taken at an edge are
// visible from that edge until the next one.
module sync_counter_monitor #(
  parameter int WIDTH        = 4,
  parameter int LOCK_MATCHES = 2,
  parameter int ERRW         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_counter_monitor_if.slave mon
);

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  localparam int               RUN_W    = $clog2(LOCK_MATCHES + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_MATCHES);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [ERRW-1:0]  ERR_MAX  = '1;

  // Counter step: wraps modulo 2^WIDTH in both directions.
  function automatic logic [WIDTH-1:0] next_value(input logic [WIDTH-1:0] c,
                                                  input logic             u);
    return u ? c + 1'b1 : c - 1'b1;
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] e);
    return (e == ERR_MAX) ? e : e + 1'b1;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_last_count;
  logic             r_last_up;
  logic             r_have_prev;
  logic [RUN_W-1:0] r_match_run;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [ERRW-1:0]  r_err_count;
  logic             r_wrap_up;
  logic             r_wrap_down;
  logic             r_dir_change;
  logic [WIDTH-1:0] r_expected;

  logic [WIDTH-1:0] w_pred;
  logic             w_hit;
  logic             w_miss;
  logic [RUN_W-1:0] w_run_inc;
  logic [ERRW-1:0]  w_err_next;
  logic             w_sticky_next;

  assign w_pred    = next_value(r_last_count, r_last_up);
  assign w_hit     = r_have_prev && (mon.count == w_pred);
  // Only a locked monitor reports errors; in LOCKED a reference always exists.
  assign w_miss    = (r_state == ST_LOCKED) && !w_hit;
  assign w_run_inc = r_match_run + 1'b1;

  // Error bookkeeping: a mismatch beats a coincident clear (clear, then count it).
  always_comb begin
    w_err_next    = r_err_count;
    w_sticky_next = r_err_sticky;
    if (w_miss) begin
      w_err_next    = mon.clr_err ? ERRW'(1) : sat_inc(r_err_count);
      w_sticky_next = 1'b1;
    end else if (mon.clr_err) begin
      w_err_next    = '0;
      w_sticky_next = 1'b0;
    end
  end

  // Sample capture, lock FSM and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACQUIRE;
      r_last_count <= '0;
      r_last_up    <= 1'b0;
      r_have_prev  <= 1'b0;
      r_match_run  <= '0;
      r_mismatch   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
      r_wrap_up    <= 1'b0;
      r_wrap_down  <= 1'b0;
      r_dir_change <= 1'b0;
      r_expected   <= '0;
    end else begin
      r_last_count <= mon.count;
      r_last_up    <= mon.up;
      r_have_prev  <= 1'b1;
      r_expected   <= next_value(mon.count, mon.up);
      r_err_count  <= w_err_next;
      r_err_sticky <= w_sticky_next;
      r_mismatch   <= 1'b0;
      r_wrap_up    <= 1'b0;
      r_wrap_down  <= 1'b0;
      r_dir_change <= 1'b0;
      case (r_state)
        ST_ACQUIRE: begin
          if (r_have_prev) begin
            if (w_hit) begin
              if (w_run_inc == RUN_LOCK) begin
                r_state     <= ST_LOCKED;
                r_match_run <= '0;
              end else begin
                r_match_run <= w_run_inc;
              end
            end else begin
              r_match_run <= '0;
            end
          end
        end
        ST_LOCKED: begin
          r_dir_change <= (mon.up != r_last_up);
          if (w_hit) begin
            r_wrap_up   <= r_last_up  && (r_last_count == CNT_MAX);
            r_wrap_down <= !r_last_up && (r_last_count == '0);
          end else begin
            // The offending sample becomes the new reference for reacquisition.
            r_mismatch  <= 1'b1;
            r_state     <= ST_ACQUIRE;
            r_match_run <= '0;
          end
        end
        default: r_state <= ST_ACQUIRE;
      endcase
    end
  end

  assign mon.locked     = (r_state == ST_LOCKED);
  assign mon.mismatch   = r_mismatch;
  assign mon.err_sticky = r_err_sticky;
  assign mon.err_count  = r_err_count;
  assign mon.wrap_up    = r_wrap_up;
  assign mon.wrap_down  = r_wrap_down;
  assign mon.dir_change = r_dir_change;
  assign mon.expected   = r_expected;

endmodule

// File: tb/tb_sync_counter_monitor.sv
// Scoreboard bench for sync_counter_monitor: a stimulus process drives
// counter samples and pushes the reference model's expected outputs;
// a monitor process pops and compares after every rising edge.
module tb_sync_counter_monitor;

  localparam int W     = 4;
  localparam int LOCKM = 2;
  localparam int E     = 8;
  localparam int MAXV  = (1 << W) - 1;
  localparam int EMAX  = (1 << E) - 1;

  typedef struct {
    int locked;
    int mismatch;
    int sticky;
    int errc;
    int wu;
    int wd;
    int dc;
    int expv;
  } exp_t;

  logic clk;
  logic rst;
  sync_counter_monitor_if #(.WIDTH(W), .ERRW(E)) mif ();

  sync_counter_monitor #(.WIDTH(W), .LOCK_MATCHES(LOCKM), .ERRW(E)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference state: plain integers describing what has been observed.
  int m_have = 0, m_lc = 0, m_lu = 0, m_locked = 0, m_run = 0, m_err = 0, m_sticky = 0;
  int cur = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, name, got, want);
    end
  endtask

  // Drive one sample and record what the monitor must report for it.
  task automatic step(input int c, input int u, input int clr, input int r);
    exp_t e;
    int   pred;
    int   mis, wu, wd, dc;
    @(negedge clk);
    rst         = (r != 0);
    mif.count   = W'(c);
    mif.up      = (u != 0);
    mif.clr_err = (clr != 0);
    mis = 0; wu = 0; wd = 0; dc = 0;
    if (r != 0) begin
      m_have = 0; m_lc = 0; m_lu = 0; m_locked = 0; m_run = 0; m_err = 0; m_sticky = 0;
      e = '{0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      if (m_have != 0) begin
        pred = (m_lc + ((m_lu != 0) ? 1 : MAXV)) % (MAXV + 1);
        if (m_locked != 0) begin
          dc = (u != m_lu) ? 1 : 0;
          if (c == pred) begin
            wu = (m_lu != 0 && c == 0) ? 1 : 0;
            wd = (m_lu == 0 && c == MAXV) ? 1 : 0;
          end else begin
            mis = 1; m_locked = 0; m_run = 0;
          end
        end else if (c == pred) begin
          m_run++;
          if (m_run == LOCKM) begin m_locked = 1; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      if (mis != 0) begin
        m_err    = (clr != 0) ? 1 : ((m_err < EMAX) ? m_err + 1 : EMAX);
        m_sticky = 1;
      end else if (clr != 0) begin
        m_err = 0; m_sticky = 0;
      end
      m_lc = c; m_lu = u; m_have = 1;
      e.locked = m_locked; e.mismatch = mis; e.sticky = m_sticky; e.errc = m_err;
      e.wu = wu; e.wd = wd; e.dc = dc;
      e.expv = (c + ((u != 0) ? 1 : MAXV)) % (MAXV + 1);
    end
    q.push_back(e);
  endtask

  // Run the counter correctly for n samples in direction u.
  task automatic run(input int n, input int u);
    for (int i = 0; i < n; i++) begin
      step(cur, u, 0, 0);
      cur = (u != 0) ? (cur + 1) % (MAXV + 1) : (cur + MAXV) % (MAXV + 1);
    end
  endtask

  // Jump the counter ahead so the next sample is a skip fault.
  task automatic fault(input int clr);
    cur = (cur + 5) % (MAXV + 1);
    step(cur, 1, clr, 0);
    cur = (cur + 1) % (MAXV + 1);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked",     int'(mif.locked),     e.locked);
        chk("mismatch",   int'(mif.mismatch),   e.mismatch);
        chk("err_sticky", int'(mif.err_sticky), e.sticky);
        chk("err_count",  int'(mif.err_count),  e.errc);
        chk("wrap_up",    int'(mif.wrap_up),    e.wu);
        chk("wrap_down",  int'(mif.wrap_down),  e.wd);
        chk("dir_change", int'(mif.dir_change), e.dc);
        chk("expected",   int'(mif.expected),   e.expv);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, u, clr, r;
    rst = 1'b1; mif.count = '0; mif.up = 1'b1; mif.clr_err = 1'b0;

    // Reset held with a non-zero count on the bus.
    for (int i = 0; i < 3; i++) step(9, 1, 0, 1);

    // Clean up-count from 0, includes 15->0 wrap.
    cur = 0;
    run(40, 1);

    // Direction switch at 3, then down through 0->15.
    while (cur != 3) run(1, 1);
    run(10, 0);

    // Skip fault 5->7, then relock on 8,9.
    while (cur != 5) run(1, 1);
    run(1, 1);
    cur = 7;
    run(4, 1);

    // Two more errors, then clear alone, then clear with a mismatch.
    for (int i = 0; i < 2; i++) begin run(3, 1); fault(0); end
    run(3, 1);
    step(cur, 1, 1, 0); cur = (cur + 1) % (MAXV + 1);
    run(2, 1);
    fault(1);
    run(3, 1);

    // Reset mid-lock at 11, then relock.
    while (cur != 11) run(1, 1);
    run(1, 1);
    step(cur, 1, 0, 1);
    cur = 0;
    run(6, 1);

    // Drive err_count into saturation and beyond.
    for (int i = 0; i < 262; i++) begin run(2, 1); fault(0); end
    run(3, 1);
    step(cur, 1, 1, 0); cur = (cur + 1) % (MAXV + 1);

    // Randomized traffic: occasional faults, direction flips, clears, resets.
    u = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) u = 1 - u;
      c   = ($urandom_range(7) == 0) ? int'($urandom_range(MAXV)) : cur;
      clr = ($urandom_range(19) == 0) ? 1 : 0;
      r   = ($urandom_range(199) == 0) ? 1 : 0;
      step(c, u, clr, r);
      cur = (u != 0) ? (c + 1) % (MAXV + 1) : (c + MAXV) % (MAXV + 1);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
